// File: rtl/mil_tx_pkg.sv
// Shared types and command-word field layout for the 1553 message scheduler.
package mil_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CW   = 2'd1,
    ST_DW   = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Command word field positions
  localparam int TR_BIT = 10;
  localparam int SA_HI  = 9;
  localparam int SA_LO  = 5;
  localparam int WC_HI  = 4;
  localparam int WC_LO  = 0;

  // Subaddresses that mark a mode code
  localparam logic [4:0] SA_MODE_LO = 5'd0;
  localparam logic [4:0] SA_MODE_HI = 5'd31;

  localparam int MAX_DW = 32;
  localparam int NDW_W  = 6;

  // Number of data words the bus controller sends after this command word.
  function automatic logic [NDW_W-1:0] cw_dw_count(input logic [15:0] cw);
    logic             tr;
    logic [4:0]       sa;
    logic [4:0]       wc;
    logic [NDW_W-1:0] n;
    tr = cw[TR_BIT];
    sa = cw[SA_HI:SA_LO];
    wc = cw[WC_HI:WC_LO];
    if (tr) begin
      // Remote terminal transmits; we only send the command word
      n = 6'd0;
    end else if ((sa == SA_MODE_LO) || (sa == SA_MODE_HI)) begin
      // Mode codes 16..31 carry one data word when received by the RT
      n = cw[WC_HI] ? 6'd1 : 6'd0;
    end else if (wc == 5'd0) begin
      n = 6'(MAX_DW);
    end else begin
      n = {1'b0, wc};
    end
    return n;
  endfunction

endpackage

// File: rtl/mil_rr_arb.sv
// Two-way arbiter for the shared transmitter.
// MIL_TX_FIXED_PRIO_EN defined: requester 0 always wins ties.
// MIL_TX_FIXED_PRIO_EN undefined: round-robin on a last-served pointer.
module mil_rr_arb import mil_tx_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

`ifdef MIL_TX_FIXED_PRIO_EN

  logic unused_s;
  assign unused_s = ^{clk, rst, take};

  // Strict priority: requester 0 first
  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end

`else

  // 1 = requester 1 was served last, so requester 0 wins the next tie
  logic last_r;

  // Round-robin pick: on a tie the requester not served last wins
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Last-served pointer moves when the scheduler accepts a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (take && (gnt != 2'b00)) begin
      last_r <= gnt[1];
    end else begin
      last_r <= last_r;
    end
  end

`endif

endmodule

// File: rtl/mil_tx_sched.sv
// Message scheduler in front of the 1553 Manchester word transmitter.
// Arbitrates two requesters, sends one command word plus 0..32 data words
// in fixed-length slots, then holds an inter-message gap.
// Tie-break mode is selected in mil_rr_arb by MIL_TX_FIXED_PRIO_EN.
module mil_tx_sched import mil_tx_pkg::*; #(
  parameter int WORD_CYC = 1000,
  parameter int GAP_CYC  = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] cw0,
  input  logic [15:0] cw1,
  input  logic [15:0] dw0,
  input  logic [15:0] dw1,
  output logic [1:0]  dw_rd,
  output logic [1:0]  done,
  output logic [1:0]  gnt,
  output logic        tx_st,
  output logic        tx_sync,
  output logic [15:0] tx_dat,
  output logic        txen
);

  localparam int SLOT_W = $clog2(WORD_CYC + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = SLOT_W'(0);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ZERO  = GAP_W'(0);

  state_t            state_r,    state_s;
  logic [SLOT_W-1:0] slot_cnt_r, slot_cnt_s;
  logic [GAP_W-1:0]  gap_cnt_r,  gap_cnt_s;
  logic [NDW_W-1:0]  rem_r,      rem_s;
  logic              win_r,      win_s;

  logic [1:0]        dw_rd_r,   dw_rd_s;
  logic [1:0]        done_r,    done_s;
  logic [1:0]        gnt_r,     gnt_s;
  logic              tx_st_r,   tx_st_s;
  logic              tx_sync_r, tx_sync_s;
  logic [15:0]       tx_dat_r,  tx_dat_s;
  logic              txen_r,    txen_s;

  logic [1:0]        arb_gnt_s;
  logic              arb_take_s;
  logic [15:0]       cw_sel_s;
  logic [15:0]       dw_sel_s;

  assign arb_take_s = (state_r == ST_IDLE);
  assign cw_sel_s   = arb_gnt_s[1] ? cw1 : cw0;
  assign dw_sel_s   = win_r ? dw1 : dw0;

  mil_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .take (arb_take_s),
    .gnt  (arb_gnt_s)
  );

  // Next state, counters and next output values
  always_comb begin
    state_s    = state_r;
    slot_cnt_s = slot_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    rem_s      = rem_r;
    win_s      = win_r;
    dw_rd_s    = 2'b00;
    done_s     = 2'b00;
    gnt_s      = gnt_r;
    tx_st_s    = 1'b0;
    tx_sync_s  = tx_sync_r;
    tx_dat_s   = tx_dat_r;
    txen_s     = txen_r;

    case (state_r)
      ST_IDLE: begin
        if (arb_gnt_s != 2'b00) begin
          state_s    = ST_CW;
          win_s      = arb_gnt_s[1];
          rem_s      = cw_dw_count(cw_sel_s);
          slot_cnt_s = SLOT_ZERO;
          tx_st_s    = 1'b1;
          tx_sync_s  = 1'b1;
          tx_dat_s   = cw_sel_s;
          txen_s     = 1'b1;
          gnt_s      = arb_gnt_s;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CW, ST_DW: begin
        if (slot_cnt_r == SLOT_LAST) begin
          if (rem_r != 6'd0) begin
            state_s    = ST_DW;
            slot_cnt_s = SLOT_ZERO;
            rem_s      = rem_r - 6'd1;
            tx_st_s    = 1'b1;
            tx_sync_s  = 1'b0;
            tx_dat_s   = dw_sel_s;
            dw_rd_s    = win_r ? 2'b10 : 2'b01;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = GAP_ZERO;
            txen_s    = 1'b0;
            gnt_s     = 2'b00;
            tx_sync_s = 1'b0;
          end
        end else begin
          slot_cnt_s = slot_cnt_r + SLOT_ONE;
        end
      end

      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_ONE;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        txen_s    = 1'b0;
        gnt_s     = 2'b00;
        tx_sync_s = 1'b0;
      end
    endcase

    // done is registered, so raise it when the upcoming cycle is the final
    // cycle of the final slot
    if (((state_s == ST_CW) || (state_s == ST_DW)) &&
        (slot_cnt_s == SLOT_LAST) && (rem_s == 6'd0)) begin
      done_s = gnt_s;
    end else begin
      done_s = 2'b00;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      slot_cnt_r <= SLOT_ZERO;
      gap_cnt_r  <= GAP_ZERO;
      rem_r      <= 6'd0;
      win_r      <= 1'b0;
      dw_rd_r    <= 2'b00;
      done_r     <= 2'b00;
      gnt_r      <= 2'b00;
      tx_st_r    <= 1'b0;
      tx_sync_r  <= 1'b0;
      tx_dat_r   <= 16'h0000;
      txen_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      slot_cnt_r <= slot_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      rem_r      <= rem_s;
      win_r      <= win_s;
      dw_rd_r    <= dw_rd_s;
      done_r     <= done_s;
      gnt_r      <= gnt_s;
      tx_st_r    <= tx_st_s;
      tx_sync_r  <= tx_sync_s;
      tx_dat_r   <= tx_dat_s;
      txen_r     <= txen_s;
    end
  end

  assign dw_rd   = dw_rd_r;
  assign done    = done_r;
  assign gnt     = gnt_r;
  assign tx_st   = tx_st_r;
  assign tx_sync = tx_sync_r;
  assign tx_dat  = tx_dat_r;
  assign txen    = txen_r;

endmodule

// File: tb/tb_mil_tx_sched.sv
// Scoreboard bench for mil_tx_sched: stimulus pushes expected messages,
// a monitor checks every cycle of every message against them.
module tb_mil_tx_sched;

  localparam int W = 1000;
  localparam int G = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] cw0, cw1, dw0, dw1;
  logic [1:0]  dw_rd, done, gnt;
  logic        tx_st, tx_sync, txen;
  logic [15:0] tx_dat;

  mil_tx_sched #(.WORD_CYC(W), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .req(req),
    .cw0(cw0), .cw1(cw1), .dw0(dw0), .dw1(dw1),
    .dw_rd(dw_rd), .done(done), .gnt(gnt),
    .tx_st(tx_st), .tx_sync(tx_sync), .tx_dat(tx_dat), .txen(txen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          w;
    logic [15:0] cw;
    int          ndw;
    int          base;
    int          start;
    bit          b2b;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_msg = 0;
  int last_sv = 1;
  int nidx[2] = '{0, 0};
  bit mon_active = 1'b0;

  logic [15:0] data0 [256];
  logic [15:0] data1 [256];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Reference rule for the number of data words behind a command word
  function automatic int model_ndw(input logic [15:0] cw);
    int tr, sa, wc;
    tr = (int'(cw) >> 10) & 1;
    sa = (int'(cw) >> 5) & 31;
    wc = int'(cw) & 31;
    if (tr == 1) return 0;
    if (sa == 0 || sa == 31) return (int'(cw) >> 4) & 1;
    return (wc == 0) ? 32 : wc;
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef MIL_TX_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last_sv;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic expect_msg(input int w, input logic [15:0] cw, input int start, input bit b2b);
    exp_t e;
    e.w = w; e.cw = cw; e.ndw = model_ndw(cw);
    e.base = nidx[w]; e.start = start; e.b2b = b2b;
    nidx[w] += e.ndw;
    last_sv = w;
    n_push++;
    expq.push_back(e);
  endtask

  // Requester-side data word sources: advance after each consumption
  initial begin
    int i0, i1;
    i0 = 0; i1 = 0;
    for (int k = 0; k < 256; k++) begin
      data0[k] = 16'($urandom);
      data1[k] = 16'($urandom);
    end
    dw0 = data0[0];
    dw1 = data1[0];
    forever begin
      @(posedge clk); #1;
      if (dw_rd[0]) begin i0++; dw0 = data0[i0 % 256]; end
      if (dw_rd[1]) begin i1++; dw1 = data1[i1 % 256]; end
    end
  end

  // Monitor: pops an expectation at each command-word start, checks each cycle
  initial begin
    exp_t e;
    int pos, total, last_end, slot;
    bit r_edge;
    logic [15:0] ew;
    logic [1:0] oh;
    logic [31:0] want, got;
    pos = 0; total = 0; last_end = 0;
    forever begin
      @(posedge clk);
      r_edge = rst;
      @(negedge clk);
      if (r_edge) begin
        chk("reset_outputs", {7'd0, tx_st, txen, gnt, tx_sync, dw_rd, done, tx_dat}, 32'd0);
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx_st) begin
          if (expq.size() == 0) begin
            chk("unexpected_start", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            mon_active = 1'b1;
            pos = 0;
            total = (1 + e.ndw) * W;
            if (e.b2b) chk("gap_to_start", 32'(cyc - last_end), 32'(G + 1));
            else       chk("req_to_start", 32'(cyc), 32'(e.start));
          end
        end else begin
          chk("idle_quiet", {26'd0, txen, dw_rd, done[0], gnt[0] | gnt[1] | done[1]}, 32'd0);
        end
      end
      if (mon_active && !r_edge) begin
        if (pos < total) begin
          slot = pos / W;
          oh = (e.w == 1) ? 2'b10 : 2'b01;
          if (slot == 0) ew = e.cw;
          else if (e.w == 1) ew = data1[(e.base + slot - 1) % 256];
          else ew = data0[(e.base + slot - 1) % 256];
          want = {7'd0, (pos % W == 0), 1'b1, oh, (slot == 0),
                  ((pos % W == 0) && slot > 0) ? oh : 2'b00,
                  (pos == total - 1) ? oh : 2'b00, ew};
          got  = {7'd0, tx_st, txen, gnt, tx_sync, dw_rd, done, tx_dat};
          chk("slot", got, want);
        end else begin
          chk("msg_end", {26'd0, txen, gnt, done[0], done[1] | dw_rd[0], dw_rd[1]}, 32'd0);
          mon_active = 1'b0;
          last_end = cyc;
          n_msg++;
        end
        pos++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 34 * W + 100; i++) begin
      @(posedge clk); #1;
      if ((w < 0) ? (done != 2'b00) : (done[w] == 1'b1)) begin ok = 1'b1; break; end
    end
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic send1(input int w, input logic [15:0] cw);
    if (w == 1) cw1 = cw; else cw0 = cw;
    expect_msg(w, cw, cyc + 1, 1'b0);
    req[w] = 1'b1;
    wait_done(w);
    req[w] = 1'b0;
    step(G + 5);
  endtask

  task automatic send_random(input int count);
    int w;
    logic [15:0] cw;
    for (int i = 0; i < count; i++) begin
      w = int'($urandom_range(0, 1));
      cw = {5'($urandom), 1'($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom_range(1, 3))};
      send1(w, cw);
    end
  endtask

  initial begin
    int w, start;
    rst = 1'b1; req = 2'b00; cw0 = 16'h0000; cw1 = 16'h0000;
    step(3);
    rst = 1'b0;
    step(2);

    send1(0, 16'h3344);   // 4 DWs
    send1(0, 16'h3744);   // transmit command: CW only
    send1(0, 16'h3011);   // mode code with data word
    send1(0, 16'h3001);   // mode code without data word
    send1(1, 16'h3340);   // WC=0 -> 32 DWs

    // Both held: grants follow the arbitration rule message by message
    cw0 = 16'h3342;
    cw1 = 16'h3744;
    w = pick(1'b1, 1'b1); expect_msg(w, (w == 1) ? cw1 : cw0, cyc + 1, 1'b0);
    w = pick(1'b1, 1'b1); expect_msg(w, (w == 1) ? cw1 : cw0, 0, 1'b1);
    w = pick(1'b1, 1'b1); expect_msg(w, (w == 1) ? cw1 : cw0, 0, 1'b1);
    req = 2'b11;
    for (int n = 0; n < 3; n++) wait_done(-1);
    req = 2'b00;
    step(G + 5);

    send_random(4);

    // Reset in the middle of a 4-DW message
    cw0 = 16'h3344;
    start = cyc + 1;
    expect_msg(0, cw0, start, 1'b0);
    req[0] = 1'b1;
    while (cyc < start + 2499) step(1);
    rst = 1'b1;
    req = 2'b00;
    step(1);
    rst = 1'b0;
    last_sv = 1;
    n_push--;
    step(2);
    cw0 = 16'h3744;
    cw1 = 16'h3001;
    w = pick(1'b1, 1'b1);
    chk("post_reset_winner_model", 32'(w), 32'd0);
    expect_msg(w, (w == 1) ? cw1 : cw0, cyc + 1, 1'b0);
    req = 2'b11;
    wait_done(-1);
    req = 2'b00;
    step(G + 5);

    for (int i = 0; i < 100 && (expq.size() != 0 || mon_active); i++) step(1);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    chk("msg_count", 32'(n_msg), 32'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
